// File: rtl/stream_mux_nx1.sv
// Registered N-to-1 valid/ready stream multiplexer with a single-entry output register.
// MODE 0 picks the channel named by sel; MODE 1 arbitrates round-robin from a rotating pointer.
module stream_mux_nx1 #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned MODE     = 0,
  parameter int unsigned SELW     = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic [SELW-1:0]           sel,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [SELW-1:0]           out_chan
);

  logic [CHANNELS-1:0] grant;
  logic [SELW-1:0]     grant_idx;
  logic [SELW-1:0]     ptr_q, ptr_d;
  logic [WIDTH-1:0]    grant_data;
  logic                load_ok;
  logic                xfer;
  logic                found;

  assign load_ok = !out_valid || out_ready;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    if (MODE == 0) begin
      // Out-of-range sel values never match a channel, so they grant nothing.
      for (int i = 0; i < CHANNELS; i++) begin
        if (sel == SELW'(i) && in_valid[i]) begin
          grant[i]  = 1'b1;
          grant_idx = SELW'(i);
        end
      end
    end else begin
      // First pass covers ptr..CHANNELS-1, second pass wraps around to 0..ptr-1.
      for (int i = 0; i < CHANNELS; i++) begin
        if (!found && in_valid[i] && SELW'(i) >= ptr_q) begin
          grant[i]  = 1'b1;
          grant_idx = SELW'(i);
          found     = 1'b1;
        end
      end
      for (int i = 0; i < CHANNELS; i++) begin
        if (!found && in_valid[i]) begin
          grant[i]  = 1'b1;
          grant_idx = SELW'(i);
          found     = 1'b1;
        end
      end
    end
  end

  always_comb begin
    grant_data = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (grant[i]) begin
        grant_data = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Gating with rst_n keeps in_ready low for the whole reset window.
  assign in_ready = (load_ok && rst_n) ? grant : '0;
  assign xfer     = load_ok && rst_n && (|grant);

  always_comb begin
    ptr_d = ptr_q;
    if (MODE != 0 && xfer) begin
      ptr_d = (grant_idx == SELW'(CHANNELS - 1)) ? '0 : grant_idx + SELW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_chan  <= '0;
      out_valid <= 1'b0;
      ptr_q     <= '0;
    end else begin
      ptr_q <= ptr_d;
      if (xfer) begin
        out_data  <= grant_data;
        out_chan  <= grant_idx;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stream_mux_nx1.sv
// Bench for stream_mux_nx1: four instances (select/round-robin, 4 and 3 channels) share stimulus
// and are checked every cycle against a queue-free transaction-level model.
module tb_stream_mux_nx1;

  logic         clk;
  logic         rst_n;
  logic [127:0] in_data;
  logic [3:0]   in_valid;
  logic [1:0]   sel;
  logic         out_ready;

  logic [3:0]  rdy0, rdy1;
  logic [2:0]  rdy2, rdy3;
  logic [31:0] od0, od1, od2, od3;
  logic        ov0, ov1, ov2, ov3;
  logic [1:0]  oc0, oc1, oc2, oc3;

  logic [3:0]  rdy [4];
  logic [31:0] od  [4];
  logic        ov  [4];
  logic [1:0]  oc  [4];

  assign rdy[0] = rdy0;
  assign rdy[1] = rdy1;
  assign rdy[2] = {1'b0, rdy2};
  assign rdy[3] = {1'b0, rdy3};
  assign od[0] = od0;
  assign od[1] = od1;
  assign od[2] = od2;
  assign od[3] = od3;
  assign ov[0] = ov0;
  assign ov[1] = ov1;
  assign ov[2] = ov2;
  assign ov[3] = ov3;
  assign oc[0] = oc0;
  assign oc[1] = oc1;
  assign oc[2] = oc2;
  assign oc[3] = oc3;

  stream_mux_nx1 #(.WIDTH(32), .CHANNELS(4), .MODE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy0),
    .sel(sel), .out_data(od0), .out_valid(ov0), .out_ready(out_ready), .out_chan(oc0)
  );
  stream_mux_nx1 #(.WIDTH(32), .CHANNELS(4), .MODE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy1),
    .sel(sel), .out_data(od1), .out_valid(ov1), .out_ready(out_ready), .out_chan(oc1)
  );
  stream_mux_nx1 #(.WIDTH(32), .CHANNELS(3), .MODE(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data[95:0]), .in_valid(in_valid[2:0]),
    .in_ready(rdy2), .sel(sel), .out_data(od2), .out_valid(ov2), .out_ready(out_ready),
    .out_chan(oc2)
  );
  stream_mux_nx1 #(.WIDTH(32), .CHANNELS(3), .MODE(0)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data[95:0]), .in_valid(in_valid[2:0]),
    .in_ready(rdy3), .sel(sel), .out_data(od3), .out_valid(ov3), .out_ready(out_ready),
    .out_chan(oc3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, required end of test");
    $fatal(1);
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state per instance.
  logic        m_valid [4];
  logic [31:0] m_data  [4];
  int          m_chan  [4];
  int          m_ptr   [4];

  function automatic bit mode_of(int d);
    return (d == 1 || d == 2);
  endfunction

  function automatic int ch_of(int d);
    return (d < 2) ? 4 : 3;
  endfunction

  function automatic logic [31:0] lane(int k);
    return in_data[k*32 +: 32];
  endfunction

  // Channel that wins this cycle if the output register can load, or -1.
  function automatic int pick(int d);
    int ch;
    int c;
    ch = ch_of(d);
    if (!mode_of(d)) begin
      if (int'(sel) < ch && in_valid[sel]) return int'(sel);
      return -1;
    end
    for (int off = 0; off < ch; off++) begin
      c = (m_ptr[d] + off) % ch;
      if (in_valid[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 4; d++) begin
      m_valid[d] = 1'b0;
      m_data[d]  = '0;
      m_chan[d]  = 0;
      m_ptr[d]   = 0;
    end
  endtask

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge with inputs already applied; returns at the next negedge.
  task automatic cycle();
    int         k [4];
    logic [3:0] e;
    #1;
    for (int d = 0; d < 4; d++) begin
      k[d] = -1;
      if (rst_n && (!m_valid[d] || out_ready)) k[d] = pick(d);
      e = '0;
      if (k[d] >= 0) e[k[d]] = 1'b1;
      chk($sformatf("dut%0d in_ready", d), 64'(rdy[d]), 64'(e));
    end
    @(posedge clk);
    for (int d = 0; d < 4; d++) begin
      if (!rst_n) begin
        m_valid[d] = 1'b0;
        m_data[d]  = '0;
        m_chan[d]  = 0;
        m_ptr[d]   = 0;
      end else if (k[d] >= 0) begin
        m_valid[d] = 1'b1;
        m_data[d]  = lane(k[d]);
        m_chan[d]  = k[d];
        if (mode_of(d)) m_ptr[d] = (k[d] + 1) % ch_of(d);
      end else if (out_ready) begin
        m_valid[d] = 1'b0;
      end
    end
    @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      chk($sformatf("dut%0d out_valid", d), 64'(ov[d]), 64'(m_valid[d]));
      chk($sformatf("dut%0d out_data", d), 64'(od[d]), 64'(m_data[d]));
      chk($sformatf("dut%0d out_chan", d), 64'(oc[d]), 64'(m_chan[d]));
    end
  endtask

  typedef struct {
    logic [3:0] valid;
    logic [1:0] sel;
    logic       ordy;
    logic [3:0] exp_rdy;
    logic       exp_ov;
    logic [1:0] exp_chan;
  } vec_t;

  vec_t tbl [7];
  int   cnt [4];

  initial begin
    tbl[0] = '{4'b1111, 2'd1, 1'b1, 4'b0010, 1'b1, 2'd1};
    tbl[1] = '{4'b1111, 2'd3, 1'b0, 4'b0000, 1'b1, 2'd1};
    tbl[2] = '{4'b0000, 2'd3, 1'b1, 4'b0000, 1'b0, 2'd1};
    tbl[3] = '{4'b1000, 2'd3, 1'b0, 4'b1000, 1'b1, 2'd3};
    tbl[4] = '{4'b1000, 2'd2, 1'b1, 4'b0000, 1'b0, 2'd3};
    tbl[5] = '{4'b0100, 2'd2, 1'b1, 4'b0100, 1'b1, 2'd2};
    tbl[6] = '{4'b1111, 2'd0, 1'b1, 4'b0001, 1'b1, 2'd0};

    // Reset with everything requesting.
    rst_n     = 1'b0;
    in_valid  = 4'hF;
    out_ready = 1'b1;
    sel       = 2'd0;
    for (int i = 0; i < 4; i++) in_data[i*32 +: 32] = 32'h100 + i;
    model_reset();
    @(negedge clk);
    cycle();
    cycle();
    rst_n = 1'b1;

    // Hand-computed vectors on the select-mode instance.
    for (int v = 0; v < 7; v++) begin
      in_valid  = tbl[v].valid;
      sel       = tbl[v].sel;
      out_ready = tbl[v].ordy;
      #1;
      chk($sformatf("vec%0d in_ready", v), 64'(rdy0), 64'(tbl[v].exp_rdy));
      cycle();
      chk($sformatf("vec%0d out_valid", v), 64'(ov0), 64'(tbl[v].exp_ov));
      chk($sformatf("vec%0d out_chan", v), 64'(oc0), 64'(tbl[v].exp_chan));
      chk($sformatf("vec%0d out_data", v), 64'(od0), 64'(32'h100 + tbl[v].exp_chan));
    end

    // Select-mode streaming from channel 2, then an out-of-range select on the 3-channel part.
    sel       = 2'd2;
    in_valid  = 4'hF;
    out_ready = 1'b1;
    for (int n = 0; n < 8; n++) begin
      for (int i = 0; i < 4; i++) in_data[i*32 +: 32] = 32'hB0 + i;
      in_data[64 +: 32] = 32'hA0 + n;
      cycle();
      chk("stream out_data", 64'(od0), 64'(32'hA0 + n));
      chk("stream out_chan", 64'(oc0), 64'd2);
    end
    sel = 2'd3;
    cycle();
    cycle();
    chk("sel out of range out_valid", 64'(ov3), 64'd0);
    chk("sel out of range in_ready", 64'(rdy3), 64'd0);

    // Backpressure holding a word, then drain and reload in one cycle.
    sel       = 2'd0;
    in_valid  = 4'b0001;
    in_data[31:0] = 32'hDEADBEEF;
    cycle();
    out_ready = 1'b0;
    in_valid  = 4'hF;
    in_data[31:0] = 32'h12345678;
    for (int n = 0; n < 5; n++) begin
      cycle();
      chk("stall out_data", 64'(od0), 64'hDEADBEEF);
      chk("stall in_ready", 64'(rdy0), 64'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("unstall in_ready", 64'(rdy0), 64'b0001);
    cycle();
    chk("reload out_valid", 64'(ov0), 64'd1);
    chk("reload out_data", 64'(od0), 64'h12345678);

    // Advance the round-robin pointer, stall, then reset mid-operation.
    for (int i = 0; i < 4; i++) in_data[i*32 +: 32] = 32'h10 * (i + 1);
    cycle();
    cycle();
    out_ready = 1'b0;
    cycle();
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 4; d++) chk($sformatf("async reset dut%0d out_valid", d), 64'(ov[d]), 64'd0);
    model_reset();
    cycle();
    rst_n = 1'b1;

    // Fairness: grants restart at channel 0 and rotate evenly.
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) cnt[i] = 0;
    for (int n = 0; n < 40; n++) begin
      cycle();
      chk("rr4 out_chan", 64'(oc1), 64'(n % 4));
      chk("rr3 out_chan", 64'(oc2), 64'(n % 3));
      if (ov1) cnt[oc1]++;
    end
    for (int i = 0; i < 4; i++) chk($sformatf("rr4 share ch%0d", i), 64'(cnt[i]), 64'd10);

    // Sparse requests alternate between channels 1 and 3.
    in_valid = 4'b1010;
    for (int n = 0; n < 4; n++) begin
      cycle();
      chk("sparse out_chan", 64'(oc1), (n % 2 == 0) ? 64'd1 : 64'd3);
    end

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      in_valid  = 4'($urandom_range(0, 15));
      sel       = 2'($urandom_range(0, 3));
      out_ready = ($urandom_range(0, 9) < 7);
      for (int i = 0; i < 4; i++) in_data[i*32 +: 32] = $urandom;
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
